// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and state encodings for the UART receive FIFO.
package uart_rx_fifo_pkg;

  localparam logic [7:0] XON  = 8'h11;
  localparam logic [7:0] XOFF = 8'h13;

  typedef enum logic {
    IDLE,
    GAP
  } rd_state_e;

  typedef enum logic [2:0] {
    RUN,
    SEND_OFF,
    GUARD_OFF,
    PAUSED,
    SEND_ON,
    GUARD_ON
  } fc_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte in/out, status and flow-control signals of the UART receive FIFO.
// master = surrounding system (UART + consumer), slave = the FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  in_received;
  logic [7:0]            in_byte;
  logic                  in_error;
  logic                  out_ready;
  logic                  out_received;
  logic [7:0]            out_byte;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  clear_overflow;
  logic [7:0]            fc_tx_byte;
  logic                  fc_transmit;
  logic                  is_transmitting;

  modport master (
    output in_received, in_byte, in_error, out_ready, clear_overflow, is_transmitting,
    input  out_received, out_byte, count, overflow, fc_tx_byte, fc_transmit
  );

  modport slave (
    input  in_received, in_byte, in_error, out_ready, clear_overflow, is_transmitting,
    output out_received, out_byte, count, overflow, fc_tx_byte, fc_transmit
  );
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// 2^DEPTH_LOG2 x 8 storage: synchronous write, combinational read.
module uart_rx_fifo_mem #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [7:0]            rdata
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH-1:0][7:0] mem;

  // Write port; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures UART byte strobes into a FIFO and replays
// them to the consumer as paced one-cycle strobes.
// Optional XON/XOFF flow control: define UART_RX_FIFO_XONXOFF_EN.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 1,
  parameter int HI_WATER   = 12,
  parameter int LO_WATER   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);
  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL     = (DEPTH_LOG2+1)'(DEPTH);
  localparam int                  GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int                  GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic [7:0]            rdata;
  logic                  push_req, full, pop, push;
  logic                  ovf;
  rd_state_e             rd_state;
  logic [GW-1:0]         gap_cnt;
  logic                  out_strobe;
  logic [7:0]            out_data;

  assign push_req = bus.in_received & ~bus.in_error;
  assign full     = (cnt == FULL);
  assign pop      = (rd_state == IDLE) && (cnt != '0) && bus.out_ready;
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);

  uart_rx_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (bus.in_byte),
    .raddr (rptr),
    .rdata (rdata)
  );

  // Write pointer and fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky overflow; clear takes priority over a same-edge drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         ovf <= 1'b0;
    else if (bus.clear_overflow)        ovf <= 1'b0;
    else if (push_req && full && !pop)  ovf <= 1'b1;
  end

  // Read FSM: pop one byte, emit a one-cycle strobe, then idle GAP_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state   <= IDLE;
      gap_cnt    <= '0;
      rptr       <= '0;
      out_strobe <= 1'b0;
      out_data   <= 8'h00;
    end else begin
      case (rd_state)
        IDLE: begin
          out_strobe <= 1'b0;
          if (pop) begin
            out_data   <= rdata;
            out_strobe <= 1'b1;
            rptr       <= rptr + 1'b1;
            gap_cnt    <= '0;
            if (GAP_CYCLES != 0) rd_state <= GAP;
          end
        end
        GAP: begin
          out_strobe <= 1'b0;
          if (gap_cnt == GW'(GAP_LAST)) rd_state <= IDLE;
          else                          gap_cnt  <= gap_cnt + 1'b1;
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

  assign bus.out_received = out_strobe;
  assign bus.out_byte     = out_data;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;

`ifdef UART_RX_FIFO_XONXOFF_EN
  localparam logic [DEPTH_LOG2:0] HI = (DEPTH_LOG2+1)'(HI_WATER);
  localparam logic [DEPTH_LOG2:0] LO = (DEPTH_LOG2+1)'(LO_WATER);

  fc_state_e  fc_state;
  logic       fc_tx;
  logic [7:0] fc_byte;

  // Flow-control FSM: XOFF at high water, XON once drained to low water.
  // Guard states give the UART a cycle to raise its busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_state <= RUN;
      fc_tx    <= 1'b0;
      fc_byte  <= 8'h00;
    end else begin
      fc_tx <= 1'b0;
      case (fc_state)
        RUN:       if (cnt >= HI) fc_state <= SEND_OFF;
        SEND_OFF:  if (!bus.is_transmitting) begin
                     fc_byte  <= XOFF;
                     fc_tx    <= 1'b1;
                     fc_state <= GUARD_OFF;
                   end
        GUARD_OFF: fc_state <= PAUSED;
        PAUSED:    if (cnt <= LO) fc_state <= SEND_ON;
        SEND_ON:   if (!bus.is_transmitting) begin
                     fc_byte  <= XON;
                     fc_tx    <= 1'b1;
                     fc_state <= GUARD_ON;
                   end
        GUARD_ON:  fc_state <= RUN;
        default:   fc_state <= RUN;
      endcase
    end
  end

  assign bus.fc_transmit = fc_tx;
  assign bus.fc_tx_byte  = fc_byte;
`else
  // No flow control: outputs tied off, busy flag and water marks unused.
  logic unused_fc;
  assign unused_fc = bus.is_transmitting | (HI_WATER < 0) | (LO_WATER < 0);

  assign bus.fc_transmit = 1'b0;
  assign bus.fc_tx_byte  = 8'h00;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer between the UART receiver and the byte consumers (monitor state machine, CPU rx path).
- Captures every `received` strobe from the UART into a small FIFO.
- Re-presents bytes to the consumer with the same one-cycle strobe + byte interface, paced by a consumer ready signal.
- Bytes arriving while the consumer is busy (mid DUMP, CPU executing) are no longer lost.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
- GAP_CYCLES, 1, minimum idle cycles between consecutive out_received strobes.
- HI_WATER, 12, fill level at or above which XOFF is sent (optional feature only).
- LO_WATER, 4, fill level at or below which XON is sent (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_received  in  1  one-cycle strobe from UART: in_byte valid.
- in_byte  in  8  received byte from UART.
- in_error  in  1  UART recv_error; byte sampled with it is discarded.
- out_ready  in  1  consumer can take a byte this cycle.
- out_received  out  1  one-cycle strobe: out_byte valid.
- out_byte  out  8  byte to consumer; held until the next strobe.
- count  out  DEPTH_LOG2+1  current fill level.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- clear_overflow  in  1  synchronous clear of overflow.
- fc_tx_byte  out  8  flow-control byte for the UART tx mux.
- fc_transmit  out  1  one-cycle transmit request for fc_tx_byte.
- is_transmitting  in  1  UART busy flag.

Behaviour:
- Reset (async, rst_n low):
  - Read/write pointers and count = 0.
  - out_received = 0, out_byte = 8'h00.
  - overflow = 0, fc_transmit = 0, fc_tx_byte = 8'h00.
  - Read FSM in IDLE; flow-control FSM in RUN.
- Write: on an edge with in_received=1 and in_error=0:
  - Not full: store at wptr, wptr+1 (wraps mod 2^DEPTH_LOG2), count+1.
  - Full: byte dropped and overflow set on the same edge, unless a pop occurs on that edge.
- Simultaneous push and pop on the same edge: both take effect, count unchanged. This holds even when full, so no overflow in that case.
- No bypass: a byte written at edge N is first poppable at edge N+1. Minimum latency is in_received high at edge N to out_received high in the cycle after edge N+1.
- overflow: clear_overflow wins over a same-edge set.
- Read FSM states:
  - IDLE: if count!=0 and out_ready=1, then out_byte <= mem[rptr], out_received <= 1, rptr+1, count-1, go GAP.
  - GAP: out_received <= 0; hold GAP_CYCLES cycles with a counter, then go IDLE. With GAP_CYCLES=0, GAP lasts zero cycles and IDLE may pop on the very next edge.
- out_ready is sampled only in IDLE. Dropping it after a strobe has no effect on that strobe.
- Empty FIFO: no strobe; out_byte keeps its last value.
- count range is 0..2^DEPTH_LOG2; full when count == 2^DEPTH_LOG2.
- Without the optional feature: fc_transmit and fc_tx_byte are constant 0, is_transmitting is ignored, and the FSM below is absent.

Optional Feature:
- Macro: UART_RX_FIFO_XONXOFF_EN
- With the macro defined, a flow-control FSM is compiled in:
  - RUN: if count >= HI_WATER, go SEND_OFF.
  - SEND_OFF: when is_transmitting=0, fc_tx_byte <= 8'h13, fc_transmit <= 1 for one cycle, go GUARD_OFF.
  - GUARD_OFF: one cycle, so the UART busy flag can rise; then go PAUSED.
  - PAUSED: if count <= LO_WATER, go SEND_ON.
  - SEND_ON: same as SEND_OFF with 8'h11; then go GUARD_ON.
  - GUARD_ON: one cycle; then go RUN.
- fc_tx_byte holds its value after the pulse.
- A fill crossing during a SEND/GUARD state is acted on only after returning to RUN or PAUSED.
- Without the macro: outputs tied off as stated in Behaviour.

Decomposition:
- Package uart_rx_fifo_pkg holds:
  - XON = 8'h11, XOFF = 8'h13.
  - Read-FSM state encodings {IDLE, GAP}.
  - Flow-control state encodings {RUN, SEND_OFF, GUARD_OFF, PAUSED, SEND_ON, GUARD_ON}.
- One sub-module: uart_rx_fifo_mem, a 2^DEPTH_LOG2 x 8 register array with synchronous write and combinational read, addressed by the pointers.

Test Plan:
- Reset then push 8'hA5, out_ready=1 → out_received high exactly one cycle, 2 clocks after the in_received strobe, out_byte=8'hA5, count returns to 0.
- Push 3 bytes 8'h01, 8'h02, 8'h03 back-to-back with out_ready=0, then raise out_ready → strobes deliver 01, 02, 03 in order, separated by exactly GAP_CYCLES=1 idle cycle.
- Push 17 bytes with out_ready=0 → count=16, overflow=1, 17th byte absent on readout. Pulse clear_overflow → overflow=0.
- FIFO full with pop and push on the same edge → count stays 16, overflow stays 0, new byte read out last.
- in_received=1 with in_error=1 → count unchanged, no strobe. Assert rst_n=0 mid-GAP → all outputs reset in the same cycle, no further strobes.
- With UART_RX_FIFO_XONXOFF_EN, push 12 bytes while is_transmitting=0 → single fc_transmit pulse with fc_tx_byte=8'h13. Drain to count 4 → single pulse with 8'h11. Hold is_transmitting=1 → pulse deferred until it drops.
